// File: rtl/tex_mem_req_arb_pkg.sv
// ---------------------------------------------------------------------------
// tex_mem_req_arb_pkg
// Shared definitions for the texture memory request arbiter: the default
// channel geometry, the request record type used on the shared channel, the
// bit position of the requester index inside the extended tag, and the
// round-robin wrap helper.
// No ports (package).
// ---------------------------------------------------------------------------
package tex_mem_req_arb_pkg;

  // Default channel geometry; the arbiter parameters default to these.
  localparam int TEX_NUM_REQS      = 4;
  localparam int TEX_DATA_WIDTH    = 512;
  localparam int TEX_ADDR_WIDTH    = 26;
  localparam int TEX_TAG_IN_WIDTH  = 8;
  localparam int TEX_DATA_SIZE     = TEX_DATA_WIDTH / 8;
  localparam int TEX_LOG_NUM_REQS  = $clog2(TEX_NUM_REQS);
  localparam int TEX_TAG_OUT_WIDTH = TEX_TAG_IN_WIDTH + TEX_LOG_NUM_REQS;

  // The requester index occupies the LSBs of the downstream tag; the request
  // packer and the response decoder both key off this position.
  localparam int TEX_MEM_TAG_IDX_LSB = 0;

  // One request as it travels on the shared channel (MSB first: rw ... tag).
  typedef struct packed {
    logic                         rw;
    logic [TEX_DATA_SIZE-1:0]     byteen;
    logic [TEX_ADDR_WIDTH-1:0]    addr;
    logic [TEX_DATA_WIDTH-1:0]    data;
    logic [TEX_TAG_OUT_WIDTH-1:0] tag;
  } tex_mem_req_t;

  // Next round-robin start position after index idx wins, wrapping to 0.
  function automatic int rrNext(input int idx, input int numReqs);
    return (idx + 1 >= numReqs) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tex_mem_req_arb_if.sv
// ---------------------------------------------------------------------------
// tex_mem_req_arb_if
// Bundles every handshake/bus signal around the arbiter: the NUM_REQS
// requester lanes (request in, response out) and the single shared memory
// channel (request out, response in).
// Modports:
//   slave  - the arbiter's view (consumes lane requests and memory responses)
//   master - the environment's view (lanes + memory side drivers)
// Signals:
//   req_valid_in/rw_in/byteen_in/addr_in/data_in/tag_in  lane requests
//   req_ready_in                                         per-lane accept
//   req_valid_out/rw_out/byteen_out/addr_out/data_out    shared request
//   req_tag_out {tag_in, winner index}, req_ready_out    downstream accept
//   rsp_valid_in/data_in/tag_in, rsp_ready_in            memory response
//   rsp_valid_out/data_out/tag_out, rsp_ready_out        per-lane response
// ---------------------------------------------------------------------------
interface tex_mem_req_arb_if #(
  parameter int NUM_REQS     = 4,
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 26,
  parameter int TAG_IN_WIDTH = 8,
  parameter int DATA_SIZE    = DATA_WIDTH / 8
);
  localparam int LOG_NUM_REQS  = $clog2(NUM_REQS);
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS;

  logic [NUM_REQS-1:0]              req_valid_in;
  logic [NUM_REQS-1:0]              req_rw_in;
  logic [NUM_REQS*DATA_SIZE-1:0]    req_byteen_in;
  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_in;
  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data_in;
  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_in;
  logic [NUM_REQS-1:0]              req_ready_in;

  logic                             req_valid_out;
  logic                             req_rw_out;
  logic [DATA_SIZE-1:0]             req_byteen_out;
  logic [ADDR_WIDTH-1:0]            req_addr_out;
  logic [DATA_WIDTH-1:0]            req_data_out;
  logic [TAG_OUT_WIDTH-1:0]         req_tag_out;
  logic                             req_ready_out;

  logic                             rsp_valid_in;
  logic [DATA_WIDTH-1:0]            rsp_data_in;
  logic [TAG_OUT_WIDTH-1:0]         rsp_tag_in;
  logic                             rsp_ready_in;

  logic [NUM_REQS-1:0]              rsp_valid_out;
  logic [NUM_REQS*DATA_WIDTH-1:0]   rsp_data_out;
  logic [NUM_REQS*TAG_IN_WIDTH-1:0] rsp_tag_out;
  logic [NUM_REQS-1:0]              rsp_ready_out;

  modport slave (
    input  req_valid_in, req_rw_in, req_byteen_in, req_addr_in, req_data_in, req_tag_in,
    output req_ready_in,
    output req_valid_out, req_rw_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out,
    input  req_ready_out,
    input  rsp_valid_in, rsp_data_in, rsp_tag_in,
    output rsp_ready_in,
    output rsp_valid_out, rsp_data_out, rsp_tag_out,
    input  rsp_ready_out
  );

  modport master (
    output req_valid_in, req_rw_in, req_byteen_in, req_addr_in, req_data_in, req_tag_in,
    input  req_ready_in,
    input  req_valid_out, req_rw_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out,
    output req_ready_out,
    output rsp_valid_in, rsp_data_in, rsp_tag_in,
    input  rsp_ready_in,
    input  rsp_valid_out, rsp_data_out, rsp_tag_out,
    output rsp_ready_out
  );

endinterface

// File: rtl/tex_mem_req_arb_skid_buf.sv
// ---------------------------------------------------------------------------
// tex_mem_req_arb_skid_buf
// Two-entry valid/ready register slice. Both in_ready_o and out_valid_o come
// straight from flops, so no ready path crosses the slice combinationally,
// while a push and a pop in the same cycle still sustain one item per cycle.
// Ports:
//   clk, reset          clock, synchronous active-high reset (empties slice)
//   in_valid_i/in_data_i/in_ready_o     upstream handshake (ready = not full)
//   out_valid_o/out_data_o/out_ready_i  downstream handshake (valid = not empty)
// ---------------------------------------------------------------------------
module tex_mem_req_arb_skid_buf #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  input  logic [DATAW-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [DATAW-1:0] out_data_o,
  input  logic             out_ready_i
);

  logic [DATAW-1:0] mem_q [2];
  logic             wrPtr_q;
  logic             rdPtr_q;
  logic             valid_q;
  logic             full_q;
  logic             push;
  logic             pop;

  // A push never lands on the head entry while it is being presented: with
  // one entry held the write pointer already points at the other slot, and
  // with two held no push is allowed. That keeps the output payload stable.
  assign push = in_valid_i && !full_q;
  assign pop  = valid_q && out_ready_i;

  // Occupancy is tracked as two flags (non-empty, full) so that both
  // handshake outputs are direct flop outputs; push+pop leaves them as is.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wrPtr_q] <= in_data_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      case ({push, pop})
        2'b10: begin
          valid_q <= 1'b1;
          full_q  <= valid_q;
        end
        2'b01: begin
          valid_q <= full_q;
          full_q  <= 1'b0;
        end
        default: begin
          valid_q <= valid_q;
          full_q  <= full_q;
        end
      endcase
    end
  end

  assign in_ready_o  = !full_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = mem_q[rdPtr_q];

endmodule

// File: rtl/tex_mem_req_arb.sv
// ---------------------------------------------------------------------------
// tex_mem_req_arb
// Round-robin arbiter sharing one memory request channel among NUM_REQS
// texture requesters. The winner's request is registered through a two-entry
// skid buffer, its tag is extended with the winner index (index in the LSBs),
// and memory responses are steered back to the requester named by that index.
// Ports:
//   clk     clock
//   reset   synchronous, active-high reset
//   bus     tex_mem_req_arb_if.slave: lane request/response signals and the
//           shared memory request/response channel
// ---------------------------------------------------------------------------
module tex_mem_req_arb
  import tex_mem_req_arb_pkg::*;
#(
  parameter int NUM_REQS     = TEX_NUM_REQS,
  parameter int DATA_WIDTH   = TEX_DATA_WIDTH,
  parameter int ADDR_WIDTH   = TEX_ADDR_WIDTH,
  parameter int TAG_IN_WIDTH = TEX_TAG_IN_WIDTH,
  parameter int DATA_SIZE    = DATA_WIDTH / 8
) (
  input  logic                clk,
  input  logic                reset,
  tex_mem_req_arb_if.slave    bus
);

  localparam int LOG_NUM_REQS  = $clog2(NUM_REQS);
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS;
  localparam int REQ_W         = 1 + DATA_SIZE + ADDR_WIDTH + DATA_WIDTH + TAG_OUT_WIDTH;

  typedef logic [LOG_NUM_REQS-1:0] idx_t;

  idx_t             rrPtr_q;
  idx_t             rrPtr_d;
  logic             armed_q;
  logic             grantFound;
  idx_t             grantIdx;
  logic             grantOk;
  logic             bufReady;
  logic             bufValid;
  logic [REQ_W-1:0] bufIn;
  logic [REQ_W-1:0] bufOut;
  idx_t             rspIdx;
  logic             rspIdxOk;

  // Find-first search starting at rrPtr_q and wrapping, so the requester just
  // after the last winner has top priority. A continuously valid requester is
  // therefore passed over by at most NUM_REQS-1 grants.
  always_comb begin : pickWinner
    int   cand;
    idx_t candIdx;
    grantFound = 1'b0;
    grantIdx   = '0;
    cand       = 0;
    candIdx    = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      cand = int'(rrPtr_q) + k;
      if (cand >= NUM_REQS) begin
        cand = cand - NUM_REQS;
      end
      candIdx = idx_t'(cand);
      if (!grantFound && bus.req_valid_in[candIdx]) begin
        grantFound = 1'b1;
        grantIdx   = candIdx;
      end
    end
  end

  // A grant only issues when the buffer has room (registered flag) and the
  // block is out of reset for at least one full cycle; armed_q provides that
  // quiet cycle after reset, and the reset term silences the reset cycle.
  assign grantOk = grantFound && bufReady && armed_q && !reset;

  // Per-lane accept is the one-hot of the winner, gated by grantOk.
  always_comb begin
    bus.req_ready_in = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      bus.req_ready_in[i] = grantOk && (grantIdx == idx_t'(i));
    end
  end

  // Winner payload, packed rw/byteen/addr/data/tag with the index appended
  // below the requester tag so the response side can peel it off the LSBs.
  always_comb begin
    bufIn = {bus.req_rw_in[grantIdx],
             bus.req_byteen_in[grantIdx * DATA_SIZE +: DATA_SIZE],
             bus.req_addr_in[grantIdx * ADDR_WIDTH +: ADDR_WIDTH],
             bus.req_data_in[grantIdx * DATA_WIDTH +: DATA_WIDTH],
             bus.req_tag_in[grantIdx * TAG_IN_WIDTH +: TAG_IN_WIDTH],
             grantIdx};
  end

  // The pointer moves past the winner only on an actual accept; otherwise
  // the same search order is kept for the next cycle.
  always_comb begin
    rrPtr_d = rrPtr_q;
    if (grantOk) begin
      rrPtr_d = idx_t'(rrNext(int'(grantIdx), NUM_REQS));
    end
  end

  // Arbiter state: pointer and the post-reset arming flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr_q <= '0;
      armed_q <= 1'b0;
    end else begin
      rrPtr_q <= rrPtr_d;
      armed_q <= 1'b1;
    end
  end

  tex_mem_req_arb_skid_buf #(
    .DATAW (REQ_W)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (grantOk),
    .in_data_i   (bufIn),
    .in_ready_o  (bufReady),
    .out_valid_o (bufValid),
    .out_data_o  (bufOut),
    .out_ready_i (bus.req_ready_out)
  );

  assign bus.req_valid_out = bufValid;
  assign {bus.req_rw_out, bus.req_byteen_out, bus.req_addr_out,
          bus.req_data_out, bus.req_tag_out} = bufOut;

  // Response steering is purely combinational: the index in the tag LSBs
  // selects the lane for valid and the lane's ready for rsp_ready_in; data
  // and the stripped tag are broadcast to every lane. An index beyond the
  // last requester (possible when NUM_REQS is not a power of two) routes
  // nowhere and is never accepted.
  always_comb begin
    rspIdx            = bus.rsp_tag_in[TEX_MEM_TAG_IDX_LSB +: LOG_NUM_REQS];
    rspIdxOk          = int'(rspIdx) < NUM_REQS;
    bus.rsp_ready_in  = 1'b0;
    bus.rsp_valid_out = '0;
    bus.rsp_data_out  = '0;
    bus.rsp_tag_out   = '0;
    if (rspIdxOk) begin
      bus.rsp_ready_in = bus.rsp_ready_out[rspIdx];
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      bus.rsp_valid_out[i] = bus.rsp_valid_in && rspIdxOk && (rspIdx == idx_t'(i));
      bus.rsp_data_out[i * DATA_WIDTH +: DATA_WIDTH] = bus.rsp_data_in;
      bus.rsp_tag_out[i * TAG_IN_WIDTH +: TAG_IN_WIDTH] =
        bus.rsp_tag_in[TAG_OUT_WIDTH-1 -: TAG_IN_WIDTH];
    end
  end

  // Guard rails: at least two requesters, and no response may name a lane
  // that does not exist.
  always_ff @(posedge clk) begin
    assert (NUM_REQS >= 2) else $error("tex_mem_req_arb needs NUM_REQS >= 2");
    if (!reset && bus.rsp_valid_in) begin
      assert (rspIdxOk) else $error("tex_mem_req_arb response index out of range");
    end
  end

endmodule

// File: tb/tb_tex_mem_req_arb.sv
// ---------------------------------------------------------------------------
// tb_tex_mem_req_arb
// Scoreboard bench for the texture memory request arbiter. A request monitor
// predicts the grant from the round-robin rules and queues the expected
// channel item; an output monitor pops and compares whenever the shared
// channel transfers. Directed phases cover reset, fairness, backpressure,
// wrap, response routing and mid-stream reset, followed by random traffic.
// ---------------------------------------------------------------------------
module tb_tex_mem_req_arb;
  import tex_mem_req_arb_pkg::*;

  localparam int N   = TEX_NUM_REQS;
  localparam int DW  = TEX_DATA_WIDTH;
  localparam int AW  = TEX_ADDR_WIDTH;
  localparam int TW  = TEX_TAG_IN_WIDTH;
  localparam int BW  = TEX_DATA_SIZE;
  localparam int LW  = TEX_LOG_NUM_REQS;
  localparam int TOW = TEX_TAG_OUT_WIDTH;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  tex_mem_req_arb_if #(
    .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW)
  ) bus ();

  tex_mem_req_arb #(
    .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int             checks = 0;
  int             errors = 0;
  tex_mem_req_t   expQ[$];
  int             deliveredIdx[$];
  logic [TOW-1:0] deliveredTag[$];
  int             modelPtr = 0;
  bit             modelArmed = 1'b0;

  // Generic comparator shared by the directed checks.
  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Compare the delivered index log against a packed list (2 bits per item,
  // first item in the LSBs).
  task automatic checkOrder(input string name, input int count, input logic [31:0] packedIdx);
    checkOutput({name, "_count"}, 64'(deliveredIdx.size()), 64'(count));
    for (int k = 0; k < count; k++) begin
      if (k < deliveredIdx.size()) begin
        checkOutput(name, 64'(deliveredIdx[k]), 64'(packedIdx[2*k +: 2]));
      end
    end
  endtask

  task automatic randomizePayload();
    for (int i = 0; i < N; i++) begin
      bus.req_rw_in[i] = 1'($urandom);
      for (int w = 0; w < BW / 32; w++) bus.req_byteen_in[i*BW + w*32 +: 32] = $urandom;
      bus.req_addr_in[i*AW +: AW] = AW'($urandom);
      for (int w = 0; w < DW / 32; w++) bus.req_data_in[i*DW + w*32 +: 32] = $urandom;
      bus.req_tag_in[i*TW +: TW] = TW'($urandom);
    end
  endtask

  // Drive one setting for a number of cycles; inputs change just after the
  // rising edge and fresh random payloads appear every cycle.
  task automatic applyStimulus(input logic [N-1:0] valid, input logic readyOut,
                               input logic rst, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      reset             = rst;
      bus.req_valid_in  = valid;
      bus.req_ready_out = readyOut;
      randomizePayload();
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #3;
  endtask

  // Request monitor: the scoreboard queue holds exactly what the buffer
  // should hold, so its size gives the expected fullness and output valid.
  always @(negedge clk) begin : reqMonitor
    int             win;
    int             c;
    logic [N-1:0]   expReady;
    tex_mem_req_t   item;
    win = -1;
    if (modelArmed && !reset && expQ.size() < 2) begin
      for (int k = 0; k < N; k++) begin
        c = (modelPtr + k) % N;
        if (win < 0 && bus.req_valid_in[c]) win = c;
      end
    end
    expReady = (win >= 0) ? (N'(1) << win) : '0;
    checkOutput("req_ready_in", 64'(bus.req_ready_in), 64'(expReady));
    checkOutput("req_valid_out", 64'(bus.req_valid_out), 64'(expQ.size() != 0));
    checkOutput("rr_ptr", 64'(dut.rrPtr_q), 64'(modelPtr));
    if (reset) begin
      expQ.delete();
      modelPtr   = 0;
      modelArmed = 1'b0;
    end else begin
      modelArmed = 1'b1;
      if (win >= 0) begin
        item.rw     = bus.req_rw_in[win];
        item.byteen = bus.req_byteen_in[win*BW +: BW];
        item.addr   = bus.req_addr_in[win*AW +: AW];
        item.data   = bus.req_data_in[win*DW +: DW];
        item.tag    = {bus.req_tag_in[win*TW +: TW], LW'(win)};
        expQ.push_back(item);
        modelPtr = (win + 1) % N;
      end
    end
  end

  // Output monitor: pops on every channel transfer and checks that a
  // stalled payload stays put.
  tex_mem_req_t heldPayload;
  bit           heldValid = 1'b0;

  always @(negedge clk) begin : outMonitor
    tex_mem_req_t got;
    tex_mem_req_t want;
    #2;
    got = {bus.req_rw_out, bus.req_byteen_out, bus.req_addr_out, bus.req_data_out, bus.req_tag_out};
    if (!reset) begin
      if (heldValid) begin
        checks++;
        if (bus.req_valid_out !== 1'b1 || got !== heldPayload) begin
          errors++;
          $display("[TB] FAIL stall_stable got %b/%h want 1/%h", bus.req_valid_out, got, heldPayload);
        end
      end
      if (bus.req_valid_out === 1'b1 && bus.req_ready_out === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_req got %h want none", got);
        end else begin
          want = expQ.pop_front();
          if (got !== want) begin
            errors++;
            $display("[TB] FAIL req_payload got %h want %h", got, want);
          end
          deliveredIdx.push_back(int'(got.tag[LW-1:0]));
          deliveredTag.push_back(got.tag);
        end
      end
      heldValid   = (bus.req_valid_out === 1'b1) && (bus.req_ready_out !== 1'b1);
      heldPayload = got;
    end else begin
      heldValid = 1'b0;
    end
  end

  initial begin : watchdog
    #1000000;
    errors++;
    $display("[TB] FAIL timeout got running want finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : stimulus
    logic [DW-1:0]  rdata;
    logic [TOW-1:0] tagv;
    logic [N-1:0]   rrdy;
    logic           rv;
    int             idx;
    logic [TW-1:0]  upper;
    logic [N-1:0]   expV;

    reset             = 1'b1;
    bus.req_valid_in  = '1;
    bus.req_ready_out = 1'b1;
    bus.rsp_valid_in  = 1'b0;
    bus.rsp_data_in   = '0;
    bus.rsp_tag_in    = '0;
    bus.rsp_ready_out = '0;
    randomizePayload();

    // Reset held with every lane requesting, then the quiet cycle.
    applyStimulus('1, 1'b1, 1'b1, 3);
    applyStimulus('1, 1'b1, 1'b0, 1);

    // Round-robin fairness: 0,1,2,3,0,1,2,3.
    deliveredIdx.delete();
    applyStimulus('1, 1'b1, 1'b0, 8);
    applyStimulus('0, 1'b1, 1'b0, 2);
    settle();
    checkOrder("rr_order", 8, 32'h0000E4E4);

    // Backpressure: two accepts (0 then 2), then full, then ordered drain.
    deliveredIdx.delete();
    applyStimulus(4'b0101, 1'b0, 1'b0, 5);
    applyStimulus('0, 1'b1, 1'b0, 3);
    settle();
    checkOrder("backpressure", 2, 32'h00000008);

    // Sparse wrap: lane 3 (tag A5) then lane 0; pointer 3 -> 0 -> 1.
    deliveredIdx.delete();
    deliveredTag.delete();
    applyStimulus(4'b1000, 1'b1, 1'b0, 1);
    bus.req_tag_in[3*TW +: TW] = 8'hA5;
    applyStimulus(4'b0001, 1'b1, 1'b0, 1);
    applyStimulus('0, 1'b1, 1'b0, 2);
    settle();
    checkOrder("sparse_wrap", 2, 32'h00000003);
    if (deliveredTag.size() > 0) checkOutput("wrap_tag", 64'(deliveredTag[0]), 64'(10'b1010010111));
    checkOutput("wrap_ptr", 64'(dut.rrPtr_q), 64'd1);

    // Response routing, directed.
    @(posedge clk);
    #2;
    rdata = '0;
    for (int w = 0; w < DW / 32; w++) rdata[w*32 +: 32] = $urandom;
    bus.rsp_valid_in  = 1'b1;
    bus.rsp_data_in   = rdata;
    bus.rsp_tag_in    = {8'h3C, 2'd2};
    bus.rsp_ready_out = 4'b0100;
    #1;
    checkOutput("rsp_valid_out", 64'(bus.rsp_valid_out), 64'(4'b0100));
    checkOutput("rsp_tag_out2", 64'(bus.rsp_tag_out[2*TW +: TW]), 64'(8'h3C));
    checkOutput("rsp_ready_in", 64'(bus.rsp_ready_in), 64'd1);
    checkOutput("rsp_data2_lo", bus.rsp_data_out[2*DW +: 64], rdata[63:0]);
    bus.rsp_ready_out = 4'b1011;
    #1;
    checkOutput("rsp_ready_in_blocked", 64'(bus.rsp_ready_in), 64'd0);

    // Response routing, random.
    for (int t = 0; t < 16; t++) begin
      for (int w = 0; w < DW / 32; w++) rdata[w*32 +: 32] = $urandom;
      tagv  = TOW'($urandom);
      rv    = 1'($urandom);
      rrdy  = N'($urandom);
      idx   = int'(tagv) % N;
      upper = TW'(tagv >> LW);
      expV  = rv ? (N'(1) << idx) : '0;
      bus.rsp_valid_in  = rv;
      bus.rsp_data_in   = rdata;
      bus.rsp_tag_in    = tagv;
      bus.rsp_ready_out = rrdy;
      #1;
      checkOutput("rsp_rand_valid", 64'(bus.rsp_valid_out), 64'(expV));
      checkOutput("rsp_rand_ready", 64'(bus.rsp_ready_in), 64'(rrdy[idx]));
      for (int i = 0; i < N; i++) begin
        checkOutput("rsp_rand_tag", 64'(bus.rsp_tag_out[i*TW +: TW]), 64'(upper));
        checkOutput("rsp_rand_data", bus.rsp_data_out[i*DW + DW - 64 +: 64], rdata[DW-1 -: 64]);
      end
    end
    bus.rsp_valid_in = 1'b0;

    // Reset mid-stream: two buffered requests are dropped, traffic restarts at 0.
    applyStimulus('1, 1'b0, 1'b0, 2);
    applyStimulus('1, 1'b0, 1'b1, 1);
    applyStimulus('1, 1'b1, 1'b0, 1);
    deliveredIdx.delete();
    applyStimulus('1, 1'b1, 1'b0, 2);
    applyStimulus('0, 1'b1, 1'b0, 2);
    settle();
    checkOrder("reset_resume", 2, 32'h00000004);

    // Random traffic with occasional resets.
    for (int t = 0; t < 400; t++) begin
      applyStimulus(N'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0), 1);
    end
    applyStimulus('0, 1'b1, 1'b0, 4);
    settle();
    checkOutput("drain_empty", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
